hs_rx: RTL and testbench
========================

Name: hs_rx

Overview:
- Receive-side counterpart of the 10-bit handshake serializer. Accepts an LSB-first serial stream qualified per bit by shift_enable. Reassembles 10-bit frames and presents each frame on a valid/ready output register to the packet decode logic.
- Detects stalled partial frames (gap timeout) and frames lost because the consumer had not accepted the previous one (overrun).

Parameters:
- FRAME_BITS, 10, bits per frame; also the width of parallel_out.
- GAP_TIMEOUT, 8, number of consecutive cycles with shift_enable low, mid-frame, that aborts the frame. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- serial_in  input  1  serial data bit; sampled only when shift_enable=1.
- shift_enable  input  1  bit strobe; one bit is captured per cycle in which it is high.
- out_ready  input  1  consumer accepts parallel_out this cycle when out_valid=1.
- parallel_out  output  FRAME_BITS  last completed frame; the first received bit is at bit 0.
- out_valid  output  1  parallel_out holds an unconsumed frame.
- busy  output  1  high while a partial frame is being received (state RECV).
- frame_error  output  1  one-cycle pulse when a partial frame is aborted by gap timeout.
- overrun  output  1  one-cycle pulse when a completed frame is dropped because the output register was still occupied.

Behaviour:
- Reset: when rst=1 at a rising edge:
  - state=IDLE, shift register=0, bit_cnt=0, gap_cnt=0.
  - parallel_out=0, out_valid=0, busy=0, frame_error=0, overrun=0.
  - Reset mid-frame discards the partial frame silently (no frame_error). Reset also clears any pending out_valid.
- Shift: each cycle with shift_enable=1, sr <= {serial_in, sr[FRAME_BITS-1:1]} and bit_cnt increments. After FRAME_BITS shifts the first bit sits at sr[0].
- States:
  - IDLE: busy=0. shift_enable=1 captures bit 1, sets bit_cnt=1 and moves to RECV.
  - RECV: busy=1.
    - shift_enable=1: capture the bit and clear gap_cnt.
    - If the capture is bit FRAME_BITS: frame complete, go to IDLE, bit_cnt=0.
    - shift_enable=0: gap_cnt increments.
    - If gap_cnt==GAP_TIMEOUT-1 and shift_enable=0: go to IDLE, clear bit_cnt and gap_cnt, pulse frame_error next cycle. Net effect: frame_error is high in the cycle after the GAP_TIMEOUT-th consecutive idle cycle.
  - shift_enable=1 always takes priority over the timeout.
- Frame completion latency: parallel_out and out_valid update at the same edge that captures the final bit. They are therefore visible in the cycle following the 10th strobe.
- Output register rules, evaluated at each edge:
  - Completion with out_valid=0: load parallel_out, out_valid<=1.
  - Completion with out_valid=1 and out_ready=1: load the new frame, out_valid stays 1, no overrun.
  - Completion with out_valid=1 and out_ready=0: new frame dropped, old frame retained, overrun pulses 1 cycle.
  - No completion with out_valid=1 and out_ready=1: out_valid<=0; parallel_out holds its last value.
- Back-to-back frames: a strobe in the cycle immediately after completion starts the next frame from IDLE with no dead cycle.
- frame_error and overrun are registered, never high for more than one cycle per event, and independent. Both may pulse in the same cycle only if the events coincide, which is impossible by construction.
- Counter widths:
  - bit_cnt is clog2(FRAME_BITS+1) bits.
  - gap_cnt is 8 bits and never exceeds GAP_TIMEOUT-1.

Decomposition:
- Shared package hs_pkg:
  - localparam HS_FRAME_BITS=10, used by the transmit and receive shifters.
  - typedef enum logic {HS_RX_IDLE, HS_RX_RECV} hs_rx_state_t.
- One natural sub-module, hs_rx_sipo: the serial-in/parallel-out shifter plus bit counter.
  - Ports: clk, rst, shift_enable, serial_in, clear, parallel, count.
- Top level holds the FSM, gap counter, output register and error pulses.

Test Plan:
- Reset, then send 10'h2B5 LSB-first (bits 1,0,1,0,1,1,0,1,0,1) on 10 consecutive strobes with out_ready=1 -> cycle after the 10th strobe: parallel_out=10'h2B5, out_valid=1, busy=0; out_valid drops one cycle later.
- Send 10'h155 with one idle cycle between strobes 5 and 6 -> parallel_out=10'h155, out_valid=1, no frame_error.
- Send 4 bits, then hold shift_enable=0 -> frame_error high for exactly one cycle after the 8th idle cycle, busy=0. Next 10 strobes of 10'h3FF -> parallel_out=10'h3FF, no remnant of the aborted bits.
- out_ready=0; send 10'h001 then 10'h3FE back-to-back -> parallel_out stays 10'h001, overrun pulses once. Raise out_ready -> out_valid clears.
- out_ready=1 in the exact cycle the second frame 10'h0F0 completes over a pending 10'h00F -> parallel_out=10'h0F0, out_valid stays 1, overrun=0.
- Assert rst after 6 bits of a frame -> all outputs 0 next cycle, no frame_error. A following full frame 10'h2AA is received correctly.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared definitions for the 10-bit handshake serial link (TX and RX sides).
// Holds the frame width and the receive FSM state type.
// No logic; imported by every hs_* module.
package hs_pkg;

  // Bits per serial frame, shared by the transmit and receive shifters.
  localparam int HS_FRAME_BITS = 10;

  // Width of the idle-gap counter; bounds the legal GAP_TIMEOUT to 1..255.
  localparam int HS_GAP_CNT_W = 8;

  // Receive FSM: waiting for the first bit, or partway through a frame.
  typedef enum logic {
    HS_RX_IDLE,
    HS_RX_RECV
  } hs_rx_state_t;

endpackage

// File: rtl/hs_rx_sipo.sv
// Serial-in/parallel-out shifter with bit counter, LSB-first (first bit lands in bit 0).
// Latency: one cycle per captured bit; 'parallel' previews the post-shift word combinationally.
// Backpressure: none; a bit is captured every cycle shift_enable is high, clear overrides.
module hs_rx_sipo
  import hs_pkg::*;
#(
  parameter int FRAME_BITS = HS_FRAME_BITS,
  parameter int CNT_W      = $clog2(FRAME_BITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_enable,
  input  logic                  serial_in,
  input  logic                  clear,
  output logic [FRAME_BITS-1:0] parallel,
  output logic [CNT_W-1:0]      count
);

  logic [FRAME_BITS-1:0] sr;
  logic [FRAME_BITS-1:0] sr_shifted;

  // New bits enter at the top and walk down, so after FRAME_BITS shifts the first bit is at bit 0.
  assign sr_shifted = {serial_in, sr[FRAME_BITS-1:1]};

  // The parent loads its output register at the same edge as the final capture, so it
  // needs the word as it will look after this cycle's shift rather than the stored one.
  assign parallel = shift_enable ? sr_shifted : sr;

  // Shift and count; clear (frame done or aborted) returns to an empty frame.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr    <= '0;
      count <= '0;
    end else if (shift_enable) begin
      sr    <= sr_shifted;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hs_rx.sv
// Receive side of the handshake link: rebuilds frames, holds them in a valid/ready register.
// Latency: frame visible the cycle after its last strobe; gap timeout after GAP_TIMEOUT idle cycles.
// Backpressure: one-deep output register; a frame completing while it is full and not taken is dropped (overrun).
module hs_rx
  import hs_pkg::*;
#(
  parameter int FRAME_BITS  = HS_FRAME_BITS,
  parameter int GAP_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic                  shift_enable,
  input  logic                  out_ready,
  output logic [FRAME_BITS-1:0] parallel_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]        LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [HS_GAP_CNT_W-1:0] GAP_LAST = HS_GAP_CNT_W'(GAP_TIMEOUT - 1);

  hs_rx_state_t            state;
  logic [HS_GAP_CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   sipo_word;
  logic                    frame_done;
  logic                    gap_expire;
  logic                    sipo_clear;

  // A strobe landing on the last bit position completes the frame; a strobe always beats the timeout.
  always_comb begin
    frame_done = shift_enable && (bit_cnt == LAST_BIT);
    gap_expire = (state == HS_RX_RECV) && !shift_enable && (gap_cnt == GAP_LAST);
    sipo_clear = frame_done || gap_expire;
  end

  hs_rx_sipo #(
    .FRAME_BITS (FRAME_BITS),
    .CNT_W      (CNT_W)
  ) u_sipo (
    .clk          (clk),
    .rst          (rst),
    .shift_enable (shift_enable),
    .serial_in    (serial_in),
    .clear        (sipo_clear),
    .parallel     (sipo_word),
    .count        (bit_cnt)
  );

  assign busy = (state == HS_RX_RECV);

  // Frame FSM with idle-gap counter; frame_error is a registered one-cycle pulse on timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HS_RX_IDLE;
      gap_cnt     <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        HS_RX_IDLE: begin
          gap_cnt <= '0;
          if (shift_enable && !frame_done) begin
            state <= HS_RX_RECV;
          end
        end
        HS_RX_RECV: begin
          if (shift_enable) begin
            gap_cnt <= '0;
            if (frame_done) begin
              state <= HS_RX_IDLE;
            end
          end else if (gap_expire) begin
            state       <= HS_RX_IDLE;
            gap_cnt     <= '0;
            frame_error <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state   <= HS_RX_IDLE;
          gap_cnt <= '0;
        end
      endcase
    end
  end

  // Output register: load a finished frame if the slot is free or being drained this cycle,
  // otherwise keep the old frame and flag the loss.
  always_ff @(posedge clk) begin
    if (rst) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (!out_valid || out_ready) begin
          parallel_out <= sipo_word;
          out_valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hs_rx.sv
// Bench for hs_rx: directed scenarios with literal expectations, then randomized traffic,
// with a queue-based reference model compared against the DUT on every falling edge.
module tb_hs_rx;
  import hs_pkg::*;

  localparam int FB = 10;
  localparam int GT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          serial_in;
  logic          shift_enable;
  logic          out_ready;
  logic [FB-1:0] parallel_out;
  logic          out_valid;
  logic          busy;
  logic          frame_error;
  logic          overrun;

  always #5 clk = ~clk;

  hs_rx #(.FRAME_BITS(FB), .GAP_TIMEOUT(GT)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .shift_enable (shift_enable),
    .out_ready    (out_ready),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: received bits of the partial frame, idle run, and the output slot.
  bit            m_bits[$];
  int            m_idle = 0;
  logic [FB-1:0] m_out  = '0;
  bit            m_valid = 1'b0;
  bit            m_fe    = 1'b0;
  bit            m_or    = 1'b0;

  task automatic model_step();
    bit            done;
    logic [FB-1:0] w;
    done = 1'b0;
    w    = '0;
    if (rst) begin
      m_bits.delete();
      m_idle  = 0;
      m_out   = '0;
      m_valid = 1'b0;
      m_fe    = 1'b0;
      m_or    = 1'b0;
    end else begin
      m_fe = 1'b0;
      m_or = 1'b0;
      if (shift_enable) begin
        m_bits.push_back(serial_in);
        m_idle = 0;
        if (m_bits.size() == FB) begin
          for (int i = 0; i < FB; i++) w[i] = m_bits[i];
          done = 1'b1;
          m_bits.delete();
        end
      end else if (m_bits.size() != 0) begin
        m_idle++;
        if (m_idle == GT) begin
          m_fe = 1'b1;
          m_bits.delete();
          m_idle = 0;
        end
      end
      if (done) begin
        if (!m_valid || out_ready) begin
          m_out   = w;
          m_valid = 1'b1;
        end else begin
          m_or = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic chk_w(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, then advance the model.
  task automatic cycle(input logic se, input logic si, input logic rdy, input logic r);
    shift_enable = se;
    serial_in    = si;
    out_ready    = rdy;
    rst          = r;
    @(posedge clk);
    #1;
    model_step();
  endtask

  // Send a whole frame LSB-first; optional single idle cycle before bit index gap_at;
  // out_ready is rdy for all strobes except the last, which uses rdy_last.
  task automatic send_frame(input logic [FB-1:0] w, input logic rdy, input logic rdy_last,
                            input int gap_at);
    for (int i = 0; i < FB; i++) begin
      if (i == gap_at) cycle(1'b0, 1'b0, rdy, 1'b0);
      cycle(1'b1, w[i], (i == FB - 1) ? rdy_last : rdy, 1'b0);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk_w("cyc_parallel_out", parallel_out, m_out);
      chk_b("cyc_out_valid", out_valid, m_valid);
      chk_b("cyc_busy", busy, m_bits.size() != 0);
      chk_b("cyc_frame_error", frame_error, m_fe);
      chk_b("cyc_overrun", overrun, m_or);
    end
  end

  initial begin
    int p_se;
    int p_rdy;
    rst          = 1'b1;
    serial_in    = 1'b0;
    shift_enable = 1'b0;
    out_ready    = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk_w("reset_parallel_out", parallel_out, 10'h000);
    chk_b("reset_out_valid", out_valid, 1'b0);
    chk_b("reset_busy", busy, 1'b0);

    // Basic frame, consumer always ready.
    send_frame(10'h2B5, 1'b1, 1'b1, -1);
    chk_w("f2b5_parallel_out", parallel_out, 10'h2B5);
    chk_w("f2b5_model", m_out, 10'h2B5);
    chk_b("f2b5_out_valid", out_valid, 1'b1);
    chk_b("f2b5_busy", busy, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk_b("f2b5_drained", out_valid, 1'b0);

    // One idle cycle inside the frame is tolerated.
    send_frame(10'h155, 1'b1, 1'b1, 5);
    chk_w("f155_parallel_out", parallel_out, 10'h155);
    chk_b("f155_out_valid", out_valid, 1'b1);
    chk_b("f155_no_error", frame_error, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Partial frame aborted by gap timeout.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'($urandom), 1'b1, 1'b0);
    for (int k = 0; k < GT - 1; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk_b("gap7_no_error", frame_error, 1'b0);
    chk_b("gap7_busy", busy, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk_b("gap8_frame_error", frame_error, 1'b1);
    chk_b("gap8_model_error", m_fe, 1'b1);
    chk_b("gap8_busy", busy, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk_b("gap9_error_cleared", frame_error, 1'b0);
    send_frame(10'h3FF, 1'b1, 1'b1, -1);
    chk_w("f3ff_parallel_out", parallel_out, 10'h3FF);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun: consumer stalled, second frame dropped.
    send_frame(10'h001, 1'b0, 1'b0, -1);
    chk_w("ovr_first", parallel_out, 10'h001);
    chk_b("ovr_first_no_overrun", overrun, 1'b0);
    send_frame(10'h3FE, 1'b0, 1'b0, -1);
    chk_w("ovr_retained", parallel_out, 10'h001);
    chk_b("ovr_pulse", overrun, 1'b1);
    chk_b("ovr_model_pulse", m_or, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk_b("ovr_pulse_end", overrun, 1'b0);
    chk_b("ovr_still_valid", out_valid, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk_b("ovr_drained", out_valid, 1'b0);

    // Ready arrives exactly when the second frame completes: replace, no overrun.
    send_frame(10'h00F, 1'b0, 1'b0, -1);
    send_frame(10'h0F0, 1'b0, 1'b1, -1);
    chk_w("swap_parallel_out", parallel_out, 10'h0F0);
    chk_b("swap_out_valid", out_valid, 1'b1);
    chk_b("swap_no_overrun", overrun, 1'b0);

    // Reset mid-frame with a frame still pending.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
    chk_b("rst_pre_busy", busy, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk_w("rst_parallel_out", parallel_out, 10'h000);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_frame_error", frame_error, 1'b0);
    chk_b("rst_overrun", overrun, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk_b("rst_silent", frame_error, 1'b0);
    send_frame(10'h2AA, 1'b1, 1'b1, -1);
    chk_w("f2aa_parallel_out", parallel_out, 10'h2AA);

    // Randomized traffic in blocks of dense, medium and sparse strobes.
    for (int blk = 0; blk < 40; blk++) begin
      case ($urandom_range(0, 2))
        0:       p_se = 90;
        1:       p_se = 50;
        default: p_se = 12;
      endcase
      p_rdy = int'($urandom_range(10, 90));
      for (int c = 0; c < 75; c++) begin
        cycle(1'($urandom_range(0, 99) < p_se), 1'($urandom),
              1'($urandom_range(0, 99) < p_rdy), 1'($urandom_range(0, 599) == 0));
      end
    end

    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk_en = 1'b0;
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
